// File: rtl/adc_capture_pkg.sv
// Shared defaults, FSM state type and helpers for the ADC lane packer.
package adc_capture_pkg;

  localparam int DEF_DATA_W    = 9;
  localparam int DEF_NUM_LANES = 96;
  localparam int DEF_PACK      = 4;
  localparam int DROP_W        = 16;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_e;

  // Index width for n groups, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/adc_lane_packer_if.sv
// Valid/ready stream carrying one packed lane group per beat.
interface adc_lane_packer_if
  import adc_capture_pkg::*;
#(
  parameter int WORD_W = DEF_PACK * DEF_DATA_W,
  parameter int GRP_W  = clog2_min1(DEF_NUM_LANES / DEF_PACK)
);

  logic [WORD_W-1:0] OUT_DATA;
  logic [GRP_W-1:0]  OUT_GRP;
  logic              OUT_LAST;
  logic              OUT_VLD;
  logic              OUT_RDY;

  modport master (
    output OUT_DATA, OUT_GRP, OUT_LAST, OUT_VLD,
    input  OUT_RDY
  );

  modport slave (
    input  OUT_DATA, OUT_GRP, OUT_LAST, OUT_VLD,
    output OUT_RDY
  );

endinterface

// File: rtl/adc_group_sel.sv
// Combinational selector: picks the PACK-lane group grp out of the hold register.
module adc_group_sel
  import adc_capture_pkg::*;
#(
  parameter  int DATA_W     = DEF_DATA_W,
  parameter  int NUM_LANES  = DEF_NUM_LANES,
  parameter  int PACK       = DEF_PACK,
  localparam int NUM_GROUPS = NUM_LANES / PACK,
  localparam int GRP_W      = clog2_min1(NUM_LANES / PACK),
  localparam int WORD_W     = PACK * DATA_W
) (
  input  logic [NUM_LANES*DATA_W-1:0] hold,
  input  logic [GRP_W-1:0]            grp,
  output logic [WORD_W-1:0]           word
);

  // NOTE: default assignment first so every path drives word and no latch is inferred.
  always_comb begin
    word = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      if (grp == GRP_W'(g)) word = hold[g*WORD_W +: WORD_W];
    end
  end

endmodule

// File: rtl/adc_lane_packer.sv
// Snapshots NUM_LANES ADC samples on a strobe and streams them PACK lanes per beat.
// Optional macro ADC_PACK_TEST_PATTERN_EN adds CFG_TP and a capture counter for ramp data.
module adc_lane_packer
  import adc_capture_pkg::*;
#(
  parameter  int DATA_W     = DEF_DATA_W,
  parameter  int NUM_LANES  = DEF_NUM_LANES,
  parameter  int PACK       = DEF_PACK,
  localparam int NUM_GROUPS = NUM_LANES / PACK,
  localparam int GRP_W      = clog2_min1(NUM_LANES / PACK),
  localparam int WORD_W     = PACK * DATA_W,
  localparam int BUS_W      = NUM_LANES * DATA_W
) (
  input  logic              CLK500M,
  input  logic              RST500M,
  input  logic [BUS_W-1:0]  ADC_DATA,
  input  logic              ADC_VLD,
  input  logic              CFG_EN,
  input  logic              CFG_MODE,
  input  logic [GRP_W-1:0]  CFG_GRP,
  input  logic              CFG_CLR,
`ifdef ADC_PACK_TEST_PATTERN_EN
  input  logic              CFG_TP,
`endif
  output logic              BUSY,
  output logic              OVF,
  output logic [DROP_W-1:0] DROP_CNT,
  adc_lane_packer_if.master out_bus
);

  if (NUM_LANES % PACK != 0) begin : g_bad_pack
    $error("adc_lane_packer: NUM_LANES must be a multiple of PACK");
  end

  state_e             state_q, state_d;
  logic               mode_q, mode_d;
  logic [GRP_W-1:0]   grp_d, grp_sel;
  logic [BUS_W-1:0]   hold_q, hold_d, cap_word;
  logic [WORD_W-1:0]  sel_word;
  logic               strobe, hs, capture, drop;

`ifdef ADC_PACK_TEST_PATTERN_EN
  logic [7:0] cnt_q;

  always_comb begin
    cap_word = ADC_DATA;
    if (CFG_TP) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        cap_word[i*DATA_W +: DATA_W] = DATA_W'(i + int'(cnt_q));
      end
    end
  end

  always_ff @(posedge CLK500M) begin
    if (RST500M)      cnt_q <= '0;
    else if (capture) cnt_q <= cnt_q + 8'd1;
  end
`else
  assign cap_word = ADC_DATA;
`endif

  // Single-mode group, clamped to the last valid group.
  assign grp_sel = (32'(CFG_GRP) >= NUM_GROUPS) ? GRP_W'(NUM_GROUPS - 1) : CFG_GRP;

  always_comb begin
    strobe  = ADC_VLD && CFG_EN;
    hs      = (state_q == ST_SEND) && out_bus.OUT_RDY;
    // A capture on the closing handshake of a burst is back-to-back, not a drop.
    capture = strobe && ((state_q == ST_IDLE) || (hs && out_bus.OUT_LAST));
    drop    = strobe && (state_q == ST_SEND) && !capture;

    state_d = state_q;
    mode_d  = mode_q;
    grp_d   = out_bus.OUT_GRP;
    hold_d  = hold_q;
    if (capture) begin
      state_d = ST_SEND;
      mode_d  = CFG_MODE;
      grp_d   = CFG_MODE ? '0 : grp_sel;
      hold_d  = cap_word;
    end else if (hs) begin
      if (out_bus.OUT_LAST) state_d = ST_IDLE;
      else                  grp_d   = out_bus.OUT_GRP + GRP_W'(1);
    end
  end

  // Next beat's word is selected ahead of the edge so OUT_DATA stays registered.
  adc_group_sel #(
    .DATA_W    (DATA_W),
    .NUM_LANES (NUM_LANES),
    .PACK      (PACK)
  ) u_group_sel (
    .hold (hold_d),
    .grp  (grp_d),
    .word (sel_word)
  );

  // NOTE: the wide hold register has no reset; it is written before any beat reads it.
  always_ff @(posedge CLK500M) begin
    if (capture) hold_q <= cap_word;
  end

  // NOTE: state is updated with non-blocking assignments only, so every read sees pre-edge values.
  always_ff @(posedge CLK500M) begin
    if (RST500M) begin
      state_q          <= ST_IDLE;
      mode_q           <= 1'b0;
      out_bus.OUT_VLD  <= 1'b0;
      out_bus.OUT_LAST <= 1'b0;
      out_bus.OUT_GRP  <= '0;
      out_bus.OUT_DATA <= '0;
      BUSY             <= 1'b0;
      OVF              <= 1'b0;
      DROP_CNT         <= '0;
    end else begin
      state_q          <= state_d;
      mode_q           <= mode_d;
      out_bus.OUT_VLD  <= (state_d == ST_SEND);
      BUSY             <= (state_d == ST_SEND);
      out_bus.OUT_LAST <= (state_d == ST_SEND) &&
                          (!mode_d || (grp_d == GRP_W'(NUM_GROUPS - 1)));
      if (capture || hs) begin
        out_bus.OUT_GRP  <= grp_d;
        out_bus.OUT_DATA <= sel_word;
      end

      // A drop in the same cycle as a clear leaves exactly one recorded drop.
      if (drop) begin
        OVF <= 1'b1;
        if (CFG_CLR)              DROP_CNT <= DROP_W'(1);
        else if (DROP_CNT != '1)  DROP_CNT <= DROP_CNT + DROP_W'(1);
      end else if (CFG_CLR) begin
        OVF      <= 1'b0;
        DROP_CNT <= '0;
      end
    end
  end

endmodule

// File: tb/tb_adc_lane_packer.sv
// Self-checking bench for adc_lane_packer: directed scenarios plus randomized bursts
// compared against a queue of expected beats built from the lane/group arithmetic.
module tb_adc_lane_packer;

  localparam int DATA_W    = 9;
  localparam int NUM_LANES = 96;
  localparam int PACK      = 4;
  localparam int NG        = NUM_LANES / PACK;
  localparam int GRP_W     = 5;
  localparam int WORD_W    = PACK * DATA_W;

  typedef struct {
    logic [GRP_W-1:0]  grp;
    logic [WORD_W-1:0] data;
    logic              last;
  } beat_t;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [NUM_LANES*DATA_W-1:0] adc_data;
  logic                        adc_vld, cfg_en, cfg_mode, cfg_clr;
  logic [GRP_W-1:0]            cfg_grp;
  logic                        busy, ovf;
  logic [15:0]                 drop_cnt;

  adc_lane_packer_if #(.WORD_W(WORD_W), .GRP_W(GRP_W)) bus ();

  adc_lane_packer dut (
    .CLK500M  (clk),
    .RST500M  (rst),
    .ADC_DATA (adc_data),
    .ADC_VLD  (adc_vld),
    .CFG_EN   (cfg_en),
    .CFG_MODE (cfg_mode),
    .CFG_GRP  (cfg_grp),
    .CFG_CLR  (cfg_clr),
`ifdef ADC_PACK_TEST_PATTERN_EN
    .CFG_TP   (1'b0),
`endif
    .BUSY     (busy),
    .OVF      (ovf),
    .DROP_CNT (drop_cnt),
    .out_bus  (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [8:0]  lanes [NUM_LANES];
  beat_t       exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [WORD_W-1:0] word_of(input int g);
    logic [WORD_W-1:0] w;
    for (int k = 0; k < PACK; k++) w[k*DATA_W +: DATA_W] = lanes[g*PACK + k];
    return w;
  endfunction

  // Expected beats of one burst, derived from mode/group rules and the lane snapshot.
  function automatic void push_burst(input bit mode, input int grp);
    int    g0, g1;
    beat_t b;
    g0 = mode ? 0 : ((grp >= NG) ? NG - 1 : grp);
    g1 = mode ? NG - 1 : g0;
    for (int g = g0; g <= g1; g++) begin
      b.grp  = GRP_W'(g);
      b.data = word_of(g);
      b.last = (g == g1);
      exp_q.push_back(b);
    end
  endfunction

  task automatic load_lanes();
    for (int i = 0; i < NUM_LANES; i++) adc_data[i*DATA_W +: DATA_W] = lanes[i];
  endtask

  // Called at a negedge in IDLE; returns at the negedge after the capture edge.
  task automatic start(input bit mode, input int grp);
    load_lanes();
    adc_vld  = 1'b1;
    cfg_en   = 1'b1;
    cfg_mode = mode;
    cfg_grp  = GRP_W'(grp);
    push_burst(mode, grp);
    @(negedge clk);
    adc_vld = 1'b0;
    check("latency_vld", 64'(bus.OUT_VLD), 64'(1));
  endtask

  // Consume expected beats until only keep remain, checking every shown beat.
  task automatic drain(input int budget, input bit rand_rdy, input int keep, output int cyc);
    cyc = 0;
    while (exp_q.size() > keep && cyc < budget) begin
      check("beat_vld",  64'(bus.OUT_VLD),  64'(1));
      check("beat_busy", 64'(busy),         64'(1));
      check("beat_grp",  64'(bus.OUT_GRP),  64'(exp_q[0].grp));
      check("beat_data", 64'(bus.OUT_DATA), 64'(exp_q[0].data));
      check("beat_last", 64'(bus.OUT_LAST), 64'(exp_q[0].last));
      bus.OUT_RDY = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.OUT_RDY) void'(exp_q.pop_front());
      @(negedge clk);
      cyc++;
    end
    if (exp_q.size() > keep) check("drain_timeout", 64'(exp_q.size()), 64'(keep));
    bus.OUT_RDY = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t held;
    int    cyc;

    rst = 1'b1; adc_data = '0; adc_vld = 1'b0; cfg_en = 1'b1;
    cfg_mode = 1'b0; cfg_grp = '0; cfg_clr = 1'b0; bus.OUT_RDY = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_vld",  64'(bus.OUT_VLD),  64'(0));
    check("rst_last", 64'(bus.OUT_LAST), 64'(0));
    check("rst_busy", 64'(busy),         64'(0));
    check("rst_ovf",  64'(ovf),          64'(0));
    check("rst_drop", 64'(drop_cnt),     64'(0));
    check("rst_grp",  64'(bus.OUT_GRP),  64'(0));
    check("rst_data", 64'(bus.OUT_DATA), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Full sweep with lane i = i.
    for (int i = 0; i < NUM_LANES; i++) lanes[i] = 9'(i);
    start(1'b1, 0);
    check("sweep_beat0", 64'(bus.OUT_DATA), 64'({9'd3, 9'd2, 9'd1, 9'd0}));
    drain(200, 1'b0, 0, cyc);
    check("sweep_cycles", 64'(cyc), 64'(NG));
    check("sweep_end_vld",  64'(bus.OUT_VLD), 64'(0));
    check("sweep_end_busy", 64'(busy),        64'(0));

    // Single group and clamp.
    start(1'b0, 5);
    check("single_grp",  64'(bus.OUT_GRP),  64'(5));
    check("single_data", 64'(bus.OUT_DATA), 64'({9'd23, 9'd22, 9'd21, 9'd20}));
    check("single_last", 64'(bus.OUT_LAST), 64'(1));
    drain(20, 1'b0, 0, cyc);
    check("single_end_vld", 64'(bus.OUT_VLD), 64'(0));
    start(1'b0, 30);
    check("clamp_grp",  64'(bus.OUT_GRP),  64'(23));
    check("clamp_data", 64'(bus.OUT_DATA), 64'({9'd95, 9'd94, 9'd93, 9'd92}));
    drain(20, 1'b0, 0, cyc);

    // Strobe with enable low in IDLE is ignored.
    adc_vld = 1'b1; cfg_en = 1'b0;
    @(negedge clk);
    adc_vld = 1'b0; cfg_en = 1'b1;
    check("noen_vld",  64'(bus.OUT_VLD), 64'(0));
    check("noen_drop", 64'(drop_cnt),    64'(0));

    // Backpressure at beat 2 with drops, an ignored strobe and drop+clear together.
    for (int i = 0; i < NUM_LANES; i++) lanes[i] = 9'($urandom);
    start(1'b1, 0);
    drain(20, 1'b0, NG - 2, cyc);
    held = exp_q[0];
    check("bp_grp2", 64'(bus.OUT_GRP), 64'(2));
    bus.OUT_RDY = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) adc_data[i*DATA_W +: DATA_W] = 9'($urandom);
    adc_vld = 1'b1; cfg_mode = 1'b0; cfg_grp = 5'd3;
    @(negedge clk);
    check("bp_hold_data1", 64'(bus.OUT_DATA), 64'(held.data));
    check("bp_hold_grp1",  64'(bus.OUT_GRP),  64'(held.grp));
    check("bp_ovf1",       64'(ovf),          64'(1));
    check("bp_drop1",      64'(drop_cnt),     64'(1));
    cfg_en = 1'b0;
    @(negedge clk);
    check("bp_hold_data2", 64'(bus.OUT_DATA), 64'(held.data));
    check("bp_noen_drop",  64'(drop_cnt),     64'(1));
    cfg_en = 1'b1; cfg_clr = 1'b1;
    @(negedge clk);
    adc_vld = 1'b0; cfg_clr = 1'b0;
    check("bp_hold_data3", 64'(bus.OUT_DATA), 64'(held.data));
    check("bp_hold_last3", 64'(bus.OUT_LAST), 64'(held.last));
    check("clrdrop_ovf",   64'(ovf),          64'(1));
    check("clrdrop_cnt",   64'(drop_cnt),     64'(1));
    drain(200, 1'b0, 0, cyc);
    check("bp_end_vld", 64'(bus.OUT_VLD), 64'(0));
    cfg_clr = 1'b1;
    @(negedge clk);
    cfg_clr = 1'b0;
    check("clr_ovf",  64'(ovf),      64'(0));
    check("clr_drop", 64'(drop_cnt), 64'(0));

    // Back-to-back capture on the grp-23 handshake.
    start(1'b1, 0);
    drain(200, 1'b0, 1, cyc);
    check("b2b_pre_grp", 64'(bus.OUT_GRP), 64'(23));
    for (int i = 0; i < NUM_LANES; i++) lanes[i] = 9'($urandom);
    load_lanes();
    adc_vld = 1'b1; cfg_mode = 1'b1;
    void'(exp_q.pop_front());
    push_burst(1'b1, 0);
    @(negedge clk);
    adc_vld = 1'b0;
    check("b2b_vld",  64'(bus.OUT_VLD),  64'(1));
    check("b2b_grp",  64'(bus.OUT_GRP),  64'(0));
    check("b2b_data", 64'(bus.OUT_DATA), 64'(word_of(0)));
    check("b2b_drop", 64'(drop_cnt),     64'(0));
    drain(200, 1'b0, 0, cyc);
    check("b2b_drop_end", 64'(drop_cnt), 64'(0));

    // Reset at beat 10, after a drop so the counter has something to clear.
    start(1'b1, 0);
    drain(50, 1'b0, NG - 10, cyc);
    adc_vld = 1'b1;
    @(negedge clk);
    adc_vld = 1'b0;
    void'(exp_q.pop_front());
    check("pre_rst_drop", 64'(drop_cnt), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    check("mid_rst_vld",  64'(bus.OUT_VLD), 64'(0));
    check("mid_rst_busy", 64'(busy),        64'(0));
    check("mid_rst_drop", 64'(drop_cnt),    64'(0));
    check("mid_rst_ovf",  64'(ovf),         64'(0));
    @(negedge clk);
    start(1'b1, 0);
    check("restart_grp", 64'(bus.OUT_GRP), 64'(0));
    drain(200, 1'b0, 0, cyc);

    // Randomized bursts under random backpressure.
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < NUM_LANES; i++) lanes[i] = 9'($urandom);
      start(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)));
      drain(1000, 1'b1, 0, cyc);
      check("rand_end_vld", 64'(bus.OUT_VLD), 64'(0));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    check("rand_no_drops", 64'(drop_cnt), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_lane_packer.md
# adc_lane_packer

Parametrised successor to the static ADC lane packer. It snapshots a flat bus of NUM_LANES ADC samples on a strobe and packs them PACK lanes per word. It then streams the packed groups over a valid/ready interface, either as a full sweep of all groups or as one selected group. It sits between the analog ADC capture boundary and the capture buffer in the 500 MHz domain, and it flags samples dropped while a burst is in flight.

## Interface
- DATA_W, 9, bits per ADC lane
- NUM_LANES, 96, lanes on ADC_DATA
- PACK, 4, lanes per output word; NUM_LANES % PACK != 0 is an elaboration error
- NUM_GROUPS (derived), NUM_LANES/PACK
- GRP_W (derived), max(1, clog2(NUM_GROUPS))

Ports:
- CLK500M  in  1  sole clock
- RST500M  in  1  synchronous, active-high reset
- ADC_DATA  in  NUM_LANES*DATA_W  lane i at [i*DATA_W +: DATA_W]
- ADC_VLD  in  1  sample strobe, one cycle per sample
- CFG_EN  in  1  capture enable
- CFG_MODE  in  1  0 = single group, 1 = sweep all groups
- CFG_GRP  in  GRP_W  group for single mode
- CFG_CLR  in  1  clears OVF and DROP_CNT
- OUT_DATA  out  PACK*DATA_W  packed group
- OUT_GRP  out  GRP_W  group index of current beat
- OUT_LAST  out  1  final beat of burst
- OUT_VLD  out  1  beat valid
- OUT_RDY  in  1  downstream accept
- BUSY  out  1  burst in flight
- OVF  out  1  sticky drop flag
- DROP_CNT  out  16  saturating count of dropped strobes

## Operation
- FSM states are IDLE and SEND.
- **IDLE.** When ADC_VLD and CFG_EN are both high, the block:
  - latches ADC_DATA into the hold register;
  - latches CFG_MODE;
  - sets the group counter to 0 in sweep mode, or to CFG_GRP in single mode. CFG_GRP >= NUM_GROUPS clamps to NUM_GROUPS-1.
  - moves to SEND.
- **SEND.** OUT_VLD=1 and BUSY=1.
  - OUT_DATA packs lane g*PACK+k at bits [k*DATA_W +: DATA_W], with the lowest lane in the LSBs.
  - OUT_GRP = g.
- **Beat handshake** is OUT_VLD && OUT_RDY.
  - Not the last beat: g increments.
  - Last beat: return to IDLE.
- **OUT_LAST** is high when g == NUM_GROUPS-1 in sweep mode, and always high in single mode.
- **Back-to-back capture.** If a last-beat handshake coincides with ADC_VLD && CFG_EN, the new sample is captured and the FSM stays in SEND with no bubble.
- **Drops.** ADC_VLD && CFG_EN in SEND, other than the back-to-back case above:
  - the sample is dropped;
  - OVF is set;
  - DROP_CNT increments and saturates at 16'hFFFF.
- **CFG_CLR** zeroes OVF and DROP_CNT. A drop in the same cycle wins: OVF=1, DROP_CNT=1.
- **ADC_VLD with CFG_EN=0** is ignored and not counted.
- **CFG_EN falling mid-burst:** the current burst completes.
- **CFG_MODE/CFG_GRP changes mid-burst** have no effect until the next capture.

## Timing
- Reset values: OUT_VLD=0, OUT_LAST=0, BUSY=0, OVF=0, DROP_CNT=0, OUT_GRP=0, OUT_DATA=0, FSM=IDLE.
- Latency: ADC_VLD sampled at edge n gives OUT_VLD=1 in cycle n+1.
- Throughput: one beat per cycle while OUT_RDY=1. A sweep burst takes NUM_GROUPS cycles minimum.
- While OUT_VLD && !OUT_RDY, OUT_DATA, OUT_GRP and OUT_LAST are held stable.
- OUT_VLD never drops without a handshake, except on reset.
- All outputs are registered.
- Reset mid-burst: at the edge where RST500M is sampled high, all state returns to reset values and the burst is discarded.

## Configuration
- Macro: ADC_PACK_TEST_PATTERN_EN.
- **Defined:**
  - adds input port CFG_TP (1 bit);
  - adds an 8-bit capture counter, reset to 0 and incremented on each accepted capture;
  - when CFG_TP=1 at capture, lane i is loaded with (i + cnt) mod 2^DATA_W instead of ADC_DATA.
- **Undefined:** the CFG_TP port and the counter are absent, and the hold register always loads ADC_DATA.

## Structure
- Package adc_capture_pkg holds:
  - default DATA_W/NUM_LANES/PACK;
  - the FSM state enum (ST_IDLE, ST_SEND);
  - the DROP_CNT width constant;
  - a clog2_min1 function for GRP_W.
- Sub-module adc_group_sel: a combinational selector from the hold register and group index to one PACK*DATA_W word. Its output feeds the OUT_DATA register.

## Test plan
- **Sweep.** NUM_LANES=96, PACK=4, lane i = i, CFG_MODE=1, one ADC_VLD, OUT_RDY=1.
  - Expect 24 consecutive beats with OUT_GRP 0..23.
  - Beat 0 OUT_DATA={9'd3,9'd2,9'd1,9'd0}.
  - OUT_LAST only on grp 23; BUSY falls after it.
- **Single mode.** CFG_MODE=0, CFG_GRP=5.
  - Expect one beat: OUT_GRP=5, OUT_DATA={9'd23,9'd22,9'd21,9'd20}, OUT_LAST=1.
- **Clamp.** CFG_GRP=30 gives one beat with OUT_GRP=23 and data {95,94,93,92}.
- **Backpressure and drops.** OUT_RDY low for 3 cycles at beat 2, with ADC_VLD pulsed mid-burst.
  - Beat 2 is held unchanged.
  - OVF=1, DROP_CNT=1.
  - CFG_CLR pulse returns both to 0.
- **Back-to-back.** ADC_VLD coincides with the grp-23 handshake.
  - Next cycle: OUT_VLD=1, OUT_GRP=0 with the new sample; DROP_CNT stays 0.
- **Reset mid-burst.** RST500M pulsed at beat 10.
  - Next cycle: OUT_VLD=0, BUSY=0, DROP_CNT=0.
  - A subsequent ADC_VLD restarts at OUT_GRP=0.
